// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: elastic byte buffer in front of the UART transmitter.
// Bytes from the equalization stage are queued in a synchronous FIFO and
// handed to the transmitter one frame at a time.
//
// Handshake: din_valid is a one-cycle write strobe with no back-pressure.
// Bytes that arrive while full is high are dropped and the sticky overflow
// flag is set. tx_en is a one-cycle launch strobe. tx_data is stable from
// tx_en until the next launch. tx_busy high means a frame is in flight.
// A new launch waits until the transmitter has raised and then dropped
// tx_busy, or until tx_busy has failed to rise within BUSY_TIMEOUT cycles.
// fsm_state exposes the launch FSM encoding for observation.
module uart_tx_fifo #(
  parameter int DEPTH        = 1024,
  parameter int ADDR_W       = 10,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [7:0]        din,
  input  logic              din_valid,
  input  logic              tx_busy,
  output logic              tx_en,
  output logic [7:0]        tx_data,
  output logic [ADDR_W:0]   fifo_count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic [1:0]        fsm_state
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int TMO_W = (BUSY_TIMEOUT < 1) ? 1 : $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_FETCH     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [7:0]        mem [DEPTH];
  logic [7:0]        rd_data;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              tmo_hit;
  logic              wr_acc;
  logic              rd_issue;
  logic              load_tx;
  logic              tmo_clr;

  // Flags decode straight from the registered count, so a write landing in
  // an empty FIFO cannot be read in the same cycle.
  assign full      = (fifo_count == CNT_W'(DEPTH));
  assign empty     = (fifo_count == '0);
  assign wr_acc    = din_valid & ~full;
  assign fsm_state = state;

  // Launch FSM state register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Launch FSM next state and control strobes.
  always_comb begin
    state_nx = state;
    rd_issue = 1'b0;
    load_tx  = 1'b0;
    tmo_clr  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty && !tx_busy) begin
          rd_issue = 1'b1;
          state_nx = S_FETCH;
        end
      end
      S_FETCH: begin
        load_tx  = 1'b1;
        tmo_clr  = 1'b1;
        state_nx = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy)      state_nx = S_WAIT_DONE;
        else if (tmo_hit) state_nx = S_IDLE;
      end
      S_WAIT_DONE: begin
        if (!tx_busy) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Storage write port; contents are not reset.
  always_ff @(posedge sys_clk) begin
    if (wr_acc) mem[wr_ptr] <= din;
  end

  // Registered read port: data is valid in the FETCH cycle.
  always_ff @(posedge sys_clk) begin
    if (rd_issue) rd_data <= mem[rd_ptr];
  end

  // Pointers, occupancy count and sticky overflow.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_acc)              wr_ptr   <= wr_ptr + 1'b1;
      if (rd_issue)            rd_ptr   <= rd_ptr + 1'b1;
      if (din_valid && full)   overflow <= 1'b1;
      case ({wr_acc, rd_issue})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Transmitter launch strobe and held byte.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      tx_en   <= 1'b0;
      tx_data <= 8'h00;
    end else begin
      tx_en <= load_tx;
      if (load_tx) tx_data <= rd_data;
    end
  end

  // Busy timeout: the counter saturates at BUSY_TIMEOUT, expiry is
  // registered, and the FSM leaves WAIT_BUSY on the edge after expiry.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      tmo_cnt <= '0;
      tmo_hit <= 1'b0;
    end else if (tmo_clr) begin
      tmo_cnt <= '0;
      tmo_hit <= 1'b0;
    end else if (state == S_WAIT_BUSY) begin
      if (tmo_cnt != TMO_W'(BUSY_TIMEOUT)) tmo_cnt <= tmo_cnt + 1'b1;
      tmo_hit <= (tmo_cnt == TMO_W'(BUSY_TIMEOUT));
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo (DEPTH=4 so full/overflow/wrap are reachable).
// Launched bytes are pushed into exp_q by the driver; a negedge monitor pops
// and compares on every tx_en pulse and records the pulse cycle.
module tb_uart_tx_fifo;

  localparam int DEPTH        = 4;
  localparam int ADDR_W       = 2;
  localparam int BUSY_TIMEOUT = 15;

  // Clock / reset
  logic sys_clk = 1'b0;
  logic sys_rst;
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  logic [7:0]      din;
  logic            din_valid;
  logic            tx_busy;
  logic            tx_en;
  logic [7:0]      tx_data;
  logic [ADDR_W:0] fifo_count;
  logic            full;
  logic            empty;
  logic            overflow;
  logic [1:0]      fsm_state;

  uart_tx_fifo #(
    .DEPTH(DEPTH),
    .ADDR_W(ADDR_W),
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .din(din),
    .din_valid(din_valid),
    .tx_busy(tx_busy),
    .tx_en(tx_en),
    .tx_data(tx_data),
    .fifo_count(fifo_count),
    .full(full),
    .empty(empty),
    .overflow(overflow),
    .fsm_state(fsm_state)
  );

  // Scoreboard state
  logic [7:0] exp_q[$];
  int         pulse_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         m_cmp = 0;
  int         m_bad = 0;
  logic [7:0] mon_exp;

  // Transmitter model control: 0 = frame of busy_len cycles starting one
  // cycle after tx_en, 1 = busy held high, 2 = busy tied low.
  int busy_mode = 2;
  int busy_len  = 0;
  int busy_left = 0;
  bit pend      = 1'b0;

  // Transmitter model
  always @(negedge sys_clk) begin
    if (busy_mode == 1) begin
      tx_busy = 1'b1;
    end else if (busy_mode == 2) begin
      tx_busy = 1'b0;
    end else begin
      if (busy_left > 0) begin
        busy_left = busy_left - 1;
        tx_busy   = (busy_left != 0);
      end else if (pend) begin
        tx_busy   = 1'b1;
        busy_left = busy_len;
        pend      = 1'b0;
      end else begin
        tx_busy = 1'b0;
      end
    end
    if (tx_en === 1'b1 && busy_mode == 0) pend = 1'b1;
  end

  // Monitor: every launch must match the oldest expected byte and must not
  // happen while the transmitter is busy.
  always @(negedge sys_clk) begin
    if (tx_en === 1'b1) begin
      pulse_q.push_back(cyc);
      m_cmp++;
      if (exp_q.size() == 0) begin
        m_bad++;
        $display("FAIL tx_en_unexpected: got launch of 0x%0h at cycle %0d, required none", tx_data, cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        if (tx_data !== mon_exp) begin
          m_bad++;
          $display("FAIL tx_data_order: got 0x%0h, required 0x%0h (cycle %0d)", tx_data, mon_exp, cyc);
        end
      end
      m_cmp++;
      if (tx_busy !== 1'b0) begin
        m_bad++;
        $display("FAIL tx_en_while_busy: got tx_busy=%b, required 0 (cycle %0d)", tx_busy, cyc);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // Driver tasks: each leaves the bench #1 after a rising edge.
  task automatic put(input logic [7:0] b, input bit sent);
    @(posedge sys_clk);
    #1;
    din       = b;
    din_valid = 1'b1;
    if (sent) exp_q.push_back(b);
  endtask

  task automatic stop();
    @(posedge sys_clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Wait until every expected byte is launched and the FSM is back in IDLE
  // with an empty FIFO; reports the peak count seen while waiting.
  task automatic wait_drain(output int peak);
    bit done;
    int k;
    peak = 0;
    done = 1'b0;
    k    = 0;
    while (!done && k < 3000) begin
      @(negedge sys_clk);
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      done = (exp_q.size() == 0) && (fsm_state == 2'd0) && (empty === 1'b1);
      k++;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d bytes still pending, required 0", exp_q.size());
      exp_q.delete();
    end
    gap(1);
  endtask

  function automatic int pulse_at(input int idx);
    if (idx < pulse_q.size()) return pulse_q[idx];
    return -1;
  endfunction

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  int n0;
  int pk;
  int k;

  // Main stimulus
  initial begin
    sys_rst   = 1'b1;
    din       = 8'h00;
    din_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge sys_clk);
    check("rst_tx_en", tx_en, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_count", fifo_count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_state", fsm_state, 0);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    gap(2);

    // Single byte: launch in cycle N+3, count 0 -> 1 -> 0.
    busy_mode = 0;
    busy_len  = 20;
    pulse_q.delete();
    put(8'hA5, 1'b1);
    n0 = cyc;
    stop();
    @(negedge sys_clk);
    check("single_count_n1", fifo_count, 1);
    check("single_empty_n1", empty, 0);
    @(negedge sys_clk);
    check("single_fetch_n2", fsm_state, 1);
    check("single_count_n2", fifo_count, 0);
    wait_drain(pk);
    check("single_pulses", pulse_q.size(), 1);
    check("single_latency", pulse_at(0), n0 + 3);
    check("single_empty_end", empty, 1);

    // Burst of five with 10-cycle frames. The first byte is read in the
    // cycle after it lands, so the count peaks at 5 written - 1 read = 4.
    // With a backlog, launches are 4 + 10 = 14 cycles apart.
    busy_len = 10;
    pulse_q.delete();
    for (int i = 1; i <= 5; i++) put(8'(i), 1'b1);
    stop();
    wait_drain(pk);
    check("burst_peak", pk, 4);
    check("burst_pulses", pulse_q.size(), 5);
    for (int i = 1; i < 5; i++) check("burst_spacing", pulse_at(i) - pulse_at(i - 1), 14);
    check("burst_overflow", overflow, 0);

    // Pointer wrap: 12 paced bytes through a 4-deep FIFO.
    busy_len = 2;
    pulse_q.delete();
    for (int i = 0; i < 12; i++) begin
      put(8'h80 + 8'(i * 7), 1'b1);
      stop();
      gap(6);
    end
    wait_drain(pk);
    check("wrap_pulses", pulse_q.size(), 12);
    check("wrap_overflow", overflow, 0);

    // Timeout: tx_busy never rises, launches are 1 + 15 + 3 cycles apart.
    busy_mode = 2;
    gap(2);
    pulse_q.delete();
    put(8'h11, 1'b1);
    n0 = cyc;
    put(8'h22, 1'b1);
    put(8'h33, 1'b1);
    stop();
    wait_drain(pk);
    check("tmo_pulses", pulse_q.size(), 3);
    check("tmo_latency", pulse_at(0), n0 + 3);
    check("tmo_spacing_1", pulse_at(1) - pulse_at(0), 1 + BUSY_TIMEOUT + 3);
    check("tmo_spacing_2", pulse_at(2) - pulse_at(1), 1 + BUSY_TIMEOUT + 3);

    // Overflow: busy held high, six writes, the last two are dropped.
    busy_mode = 1;
    gap(2);
    pulse_q.delete();
    for (int i = 0; i < 6; i++) put(8'hE1 + 8'(i), (i < 4));
    stop();
    @(negedge sys_clk);
    check("ovf_count", fifo_count, 4);
    check("ovf_full", full, 1);
    check("ovf_empty", empty, 0);
    check("ovf_flag", overflow, 1);
    check("ovf_no_launch", pulse_q.size(), 0);
    busy_mode = 0;
    busy_len  = 3;
    wait_drain(pk);
    check("ovf_pulses", pulse_q.size(), 4);
    check("ovf_sticky", overflow, 1);
    check("ovf_full_end", full, 0);

    // Reset in the middle of a transfer.
    busy_len = 20;
    pulse_q.delete();
    put(8'h71, 1'b1);
    put(8'h72, 1'b0);
    put(8'h73, 1'b0);
    stop();
    k = 0;
    while (fsm_state != 2'd3 && k < 100) begin
      @(negedge sys_clk);
      k++;
    end
    check("mid_wait_done", fsm_state, 3);
    check("mid_count", fifo_count, 2);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
    #1;
    check("mid_rst_tx_en", tx_en, 0);
    check("mid_rst_tx_data", tx_data, 8'h00);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_full", full, 0);
    check("mid_rst_overflow", overflow, 0);
    check("mid_rst_state", fsm_state, 0);
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    gap(40);
    check("mid_no_launch", pulse_q.size(), 1);
    put(8'h5A, 1'b1);
    stop();
    wait_drain(pk);
    check("mid_new_pulses", pulse_q.size(), 2);

    // Final report
    gap(2);
    n_cmp += m_cmp;
    n_bad += m_bad;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
